// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the default operand width.
package mult_div_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } opCode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/unidad_mult_div_if.sv
// Pipeline-side bus of the multiply/divide unit.
// master: pipeline (drives start/op/operands/MT*/mf_sel, reads status and HI/LO)
// slave : unidad_mult_div
//   start, op[1:0], ReadData1 (rs), ReadData2 (rt), mthi, mtlo, mf_sel
//   busy, done, hi, lo, mf_data
interface unidad_mult_div_if
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             mthi;
  logic             mtlo;
  logic             mf_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output start, op, ReadData1, ReadData2, mthi, mtlo, mf_sel,
    input  busy, done, hi, lo, mf_data
  );

  modport slave (
    input  start, op, ReadData1, ReadData2, mthi, mtlo, mf_sel,
    output busy, done, hi, lo, mf_data
  );

endinterface

// File: rtl/paso_mult_div.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   accIn   : {upper, lower} accumulator
//   operand : multiplicand (multiply) or divisor (divide) magnitude
//   isDiv   : 1 = restoring-divide step, 0 = shift-add multiply step
//   inBit   : multiplier LSB (multiply) or next dividend MSB (divide)
//   accOut  : accumulator after this iteration
module paso_mult_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   operand,
  input  logic               isDiv,
  input  logic               inBit,
  output logic [2*WIDTH-1:0] accOut
);

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] shiftedRem;
  logic [WIDTH:0] trialDiff;

  always_comb begin
    // Multiply: carry out of the upper-half add becomes the new product MSB.
    addSum     = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (inBit ? {1'b0, operand} : '0);
    // Divide: dividend bits are fed in from outside, quotient grows in the lower half.
    shiftedRem = {accIn[2*WIDTH-1:WIDTH], inBit};
    trialDiff  = shiftedRem - {1'b0, operand};
    if (isDiv) begin
      if (!trialDiff[WIDTH]) begin
        accOut = {trialDiff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
      end else begin
        accOut = {shiftedRem[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      end
    end else begin
      accOut = {addSum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/unidad_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO/MF* access.
//   clk, rst (synchronous, active high)
//   bus.start/op/ReadData1/ReadData2 : launch an operation (sampled in IDLE only)
//   bus.mthi/mtlo                    : write ReadData1 into HI/LO when idle
//   bus.mf_sel                       : 0 -> LO, 1 -> HI on mf_data (combinational)
//   bus.busy, bus.done, bus.hi, bus.lo, bus.mf_data
module unidad_mult_div
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  unidad_mult_div_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_t           state, stateNext;
  logic [CNT_W-1:0] iterCnt;
  logic [ACC_W-1:0] acc, accNext, prodFinal;
  logic [WIDTH-1:0] fixedOp, shiftOp, hiReg, loReg;
  logic [WIDTH-1:0] absRs, absRt, quot, rem, resHi, resLo;
  logic             divMode, signA, signB, doneReg, inBit, lastIter;
  logic             loadOps, stepEn, finishWr, mtHiWr, mtLoWr;
  logic             reqDiv, reqSigned;
  opCode_t          reqOp;

  assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (lastIter)  stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs; start has priority over MT writes in IDLE
  always_comb begin
    loadOps  = 1'b0;
    stepEn   = 1'b0;
    finishWr = 1'b0;
    mtHiWr   = 1'b0;
    mtLoWr   = 1'b0;
    bus.busy = (state != IDLE);
    case (state)
      IDLE: begin
        loadOps = bus.start;
        mtHiWr  = bus.mthi & ~bus.start;
        mtLoWr  = bus.mtlo & ~bus.start;
      end
      RUN:     stepEn   = 1'b1;
      FINISH:  finishWr = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; |0x80000000| stays 0x80000000 and is used unsigned
  always_comb begin
    reqOp     = opCode_t'(bus.op);
    reqDiv    = (reqOp == OP_DIVU) || (reqOp == OP_DIV);
    reqSigned = (reqOp == OP_MULT) || (reqOp == OP_DIV);
    absRs     = (reqSigned && bus.ReadData1[WIDTH-1]) ? -bus.ReadData1 : bus.ReadData1;
    absRt     = (reqSigned && bus.ReadData2[WIDTH-1]) ? -bus.ReadData2 : bus.ReadData2;
  end

  assign inBit = divMode ? shiftOp[WIDTH-1] : shiftOp[0];

  paso_mult_div #(.WIDTH(WIDTH)) uPaso (
    .accIn   (acc),
    .operand (fixedOp),
    .isDiv   (divMode),
    .inBit   (inBit),
    .accOut  (accNext)
  );

  // Sign correction; a zero divisor forces an all-ones quotient
  always_comb begin
    quot      = acc[WIDTH-1:0];
    rem       = acc[ACC_W-1:WIDTH];
    prodFinal = (signA ^ signB) ? -acc : acc;
    if (divMode) begin
      resLo = (fixedOp == '0) ? '1 : ((signA ^ signB) ? -quot : quot);
      resHi = signA ? -rem : rem;
    end else begin
      resHi = prodFinal[ACC_W-1:WIDTH];
      resLo = prodFinal[WIDTH-1:0];
    end
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      iterCnt <= '0;
      fixedOp <= '0;
      shiftOp <= '0;
      divMode <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= finishWr;
      if (loadOps) begin
        divMode <= reqDiv;
        signA   <= reqSigned & bus.ReadData1[WIDTH-1];
        signB   <= reqSigned & bus.ReadData2[WIDTH-1];
        fixedOp <= reqDiv ? absRt : absRs;
        shiftOp <= reqDiv ? absRs : absRt;
        acc     <= '0;
        iterCnt <= '0;
      end
      if (stepEn) begin
        acc     <= accNext;
        iterCnt <= iterCnt + CNT_W'(1);
        shiftOp <= divMode ? (shiftOp << 1) : (shiftOp >> 1);
      end
      if (finishWr) begin
        hiReg <= resHi;
        loReg <= resLo;
      end
      if (mtHiWr) hiReg <= bus.ReadData1;
      if (mtLoWr) loReg <= bus.ReadData1;
    end
  end

  assign bus.done    = doneReg;
  assign bus.hi      = hiReg;
  assign bus.lo      = loReg;
  assign bus.mf_data = bus.mf_sel ? hiReg : loReg;

endmodule

// File: tb/tb_unidad_mult_div.sv
// Self-checking bench for unidad_mult_div: table of directed operations with
// hand-computed HI/LO, plus hand-written MT/ignore/reset sequences.
module tb_unidad_mult_div;
  import mult_div_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unidad_mult_div_if #(.WIDTH(W)) bus ();

  unidad_mult_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    opCode_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, optionally with MT* on the start cycle or an ignored
  // start+MT pulse injected while busy, then check timing and HI/LO.
  task automatic runOp(input opCode_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input string name, input int injectAt, input bit withMt);
    int          busyCycles;
    bit          gotDone;
    logic [31:0] hiBefore;
    @(negedge clk);
    hiBefore      = bus.hi;
    bus.op        = op;
    bus.ReadData1 = a;
    bus.ReadData2 = b;
    bus.start     = 1'b1;
    bus.mthi      = withMt;
    bus.mtlo      = withMt;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.ReadData1 = ~a;
    bus.ReadData2 = ~b;
    if (withMt) check({name, " mt dropped"}, 64'(bus.hi), 64'(hiBefore));
    busyCycles = 0;
    gotDone    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        gotDone = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
      if (injectAt >= 0 && i == injectAt + 1)
        check({name, " hi during run"}, 64'(bus.hi), 64'(hiBefore));
      if (i == injectAt) begin
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.mthi      = 1'b1;
        bus.mtlo      = 1'b1;
        bus.ReadData1 = 32'hDEAD0000;
      end else begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check({name, " done seen"}, 64'(gotDone), 64'(1));
    if (gotDone) begin
      check({name, " busy cycles"}, 64'(busyCycles), 64'(33));
      check({name, " busy low"}, 64'(bus.busy), 64'(0));
      check({name, " hi"}, 64'(bus.hi), 64'(expHi));
      check({name, " lo"}, 64'(bus.lo), 64'(expLo));
      @(negedge clk);
      check({name, " done one cycle"}, 64'(bus.done), 64'(0));
    end
  endtask

  initial begin
    bit doneDuringReset;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3x7"};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu 7/2"};
    vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu 100/0"};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"};
    vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu shift"};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div -8/0"};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu big/16"};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.op        = OP_MULTU;
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.mf_sel    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    check("reset mf_data", 64'(bus.mf_data), 64'(0));

    for (int v = 0; v < 11; v++)
      runOp(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].expHi, vecs[v].expLo, vecs[v].name, -1, 1'b0);

    // MTHI alone, then MTHI+MTLO together
    @(negedge clk);
    bus.mthi      = 1'b1;
    bus.ReadData1 = 32'h00001234;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi lo kept", 64'(bus.lo), 64'h0FFFFFFF);
    bus.mf_sel = 1'b1;
    #1;
    check("mf_data hi", 64'(bus.mf_data), 64'h1234);
    @(negedge clk);
    bus.mthi      = 1'b1;
    bus.mtlo      = 1'b1;
    bus.ReadData1 = 32'h0000ABCD;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mt both hi", 64'(bus.hi), 64'hABCD);
    check("mt both lo", 64'(bus.lo), 64'hABCD);
    bus.mf_sel = 1'b0;
    #1;
    check("mf_data lo", 64'(bus.mf_data), 64'hABCD);

    // start wins over MT in IDLE
    runOp(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, "start vs mt", -1, 1'b1);

    // start+MT pulse at cycle 5 of a running op is ignored
    runOp(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "ignore busy", 5, 1'b0);

    // Reset at cycle 10 of a DIV
    @(negedge clk);
    bus.op        = OP_DIV;
    bus.ReadData1 = 32'hFFFFFFF9;
    bus.ReadData2 = 32'd2;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid busy", 64'(bus.busy), 64'(0));
    check("rst mid hi", 64'(bus.hi), 64'(0));
    check("rst mid lo", 64'(bus.lo), 64'(0));
    check("rst mid done", 64'(bus.done), 64'(0));
    doneDuringReset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) doneDuringReset = 1'b1;
      @(negedge clk);
    end
    check("rst no late done", 64'(doneDuringReset), 64'(0));
    runOp(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "after reset 5x6", -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidad_mult_div.md
# unidad_mult_div

Iterative multiply/divide unit for the MIPS datapath. It consumes the two register-bank read operands (rs in ReadData1, rt in ReadData2) and executes MULT, MULTU, DIV and DIVU into private HI/LO registers. It also serves MTHI/MTLO writes and MFHI/MFLO reads. `busy` feeds the hazard/stall logic; `mf_data` feeds the write-back mux in front of the register bank's WriteData.

## Interface
- WIDTH, 32, operand/register width; the iteration count equals WIDTH.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin the operation in `op`; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- ReadData1  in  WIDTH  rs operand: multiplicand or dividend.
- ReadData2  in  WIDTH  rt operand: multiplier or divisor.
- mthi  in  1  write ReadData1 into HI.
- mtlo  in  1  write ReadData1 into LO.
- mf_sel  in  1  0 selects LO onto mf_data, 1 selects HI.
- busy  out  1  operation in progress; the pipeline must stall MF*/MT*/new mult-div.
- done  out  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_data  out  WIDTH  combinational `mf_sel ? hi : lo`.

## Operation
- FSM states: IDLE, RUN, FINISH. `busy = (state != IDLE)`.
- IDLE:
  - On `start`, latch operand magnitudes (absolute value for signed ops), both sign bits and `op`; clear the 64-bit accumulator and the 6-bit counter; go to RUN.
  - Otherwise, `mthi`/`mtlo` write ReadData1 to HI/LO. Both may be asserted together; both are written.
- RUN, one iteration per cycle for WIDTH cycles; leave to FINISH when the counter reaches WIDTH-1.
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half; shift the product right 1.
  - Divide: restoring. Shift {rem, quot} left 1; trial-subtract the divisor; on no borrow, keep the difference and set the quotient LSB.
- FINISH, 1 cycle: apply sign correction, write HI/LO, assert `done` next cycle, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^WIDTH, or 2^(2·WIDTH) for products.
  - Absolute value of 0x80000000 is 0x80000000, treated as unsigned.
- Division by zero: takes the normal latency. LO = all ones; HI = rs, unchanged from the dividend for DIVU and for DIV.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- Priority and ignore rules:
  - `start` while busy is ignored.
  - `mthi`/`mtlo` while busy are ignored.
  - `start` together with `mthi`/`mtlo` in IDLE: start wins, the MT write is dropped.
- Reset values: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter 0.
- Reset mid-operation: the operation is abandoned and the block returns to IDLE with the reset values above. No partial HI/LO update.

## Timing
- The edge sampling `start` is E0. busy is high from after E0 through the cycle ending at E33, i.e. 33 cycles.
- RUN spans E1..E32. HI/LO are written at E33.
- After E33: done = 1 for exactly one cycle, busy = 0, and new HI/LO are visible.
  - A new `start` is accepted at E34.
- MTHI/MTLO: write at the sampling edge; visible on hi/lo/mf_data the next cycle.
- mf_data has zero latency from hi/lo/mf_sel.

## Structure
- Shared package `mult_div_pkg`: op codes OP_MULTU/OP_MULT/OP_DIVU/OP_DIV, state typedef (IDLE/RUN/FINISH), default WIDTH.
- One sub-module is natural: `paso_mult_div`, the combinational single-iteration datapath. Inputs are the accumulator, operand and op class; outputs are the next accumulator. The top level holds the FSM, counter, HI/LO and sign handling.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. done exactly one cycle at E34; busy high 33 cycles.
- MULT -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 2 → LO = 3, HI = 1.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Ignore rules: `start` and `mthi` pulsed at cycle 5 of a running op → result and HI/LO unaffected.
  - After done, `mthi` with rs = 0x1234 → hi = 0x1234 next cycle; mf_sel = 1 → mf_data = 0x1234.
- Reset: assert `rst` at cycle 10 of a DIV → next cycle busy = 0, hi = lo = 0, no done pulse. A new MULTU 5 × 6 then gives LO = 30, HI = 0.
